fp_add_normalizer: RTL and testbench

- Second stage of the single-precision FP adder, directly downstream of the operand aligner.
- Accepts the larger exponent, both effective signs and the two 27-bit guarded, aligned mantissas (hidden bit, 23 fraction bits, G, R, S).
- Performs magnitude add/subtract, iterative one-bit-per-cycle normalization, and round-to-nearest-even.
- Emits a packed IEEE-754 binary32 result through a valid/ready handshake.

---
 rtl/fp_add_normalizer.sv | 192 +++++++++++++++++++
 tb/tb_fp_add_normalizer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/fp_add_normalizer.sv
// Second stage of the binary32 adder: magnitude add/sub, normalize, round-to-nearest-even, pack.
// Define FP_NORM_LZC_EN for single-cycle normalization through a leading-zero counter.
module fp_add_normalizer #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [EXP_W-1:0]        e,
  input  logic                    sign,
  input  logic                    sign_2,
  input  logic [FRAC_W+3:0]       m_1,
  input  logic [FRAC_W+3:0]       m_2,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [EXP_W+FRAC_W:0]   result,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int MW = FRAC_W + 4;
  localparam logic [EXP_W:0] EXP_ONE = (EXP_W+1)'(1);
  localparam logic [EXP_W:0] EXP_MAX = {1'b0, {EXP_W{1'b1}}};

  typedef enum logic [2:0] {S_IDLE, S_ADD, S_NORM, S_ROUND, S_DONE} state_t;

  state_t                 r_state, w_next;
  logic [EXP_W:0]         r_exp, w_exp_n;
  logic                   r_sign, w_sign_n;
  logic                   r_sign2, w_sign2_n;
  logic [MW-1:0]          r_m1, w_m1_n;
  logic [MW-1:0]          r_m2, w_m2_n;
  logic [MW-1:0]          r_mant, w_mant_n;
  logic [EXP_W+FRAC_W:0]  r_result, w_result_n;
  logic                   r_ovf, w_ovf_n;
  logic                   r_unf, w_unf_n;

  logic [MW:0]            w_sum, w_diff, w_m;
  logic                   w_ge, w_same;
  logic                   w_up;
  logic [FRAC_W+1:0]      w_rnd;
  logic [EXP_W:0]         w_exp_r;

`ifdef FP_NORM_LZC_EN
  localparam int LZW = $clog2(MW + 1);

  function automatic logic [LZW-1:0] lzc(input logic [MW-1:0] v);
    lzc = LZW'(MW);
    for (int unsigned i = 0; i < MW; i++)
      if (v[i]) lzc = LZW'(MW - 1 - i);
  endfunction

  logic [LZW-1:0]  w_lzc;
  logic [EXP_W:0]  w_lzc_ext;
  assign w_lzc     = lzc(r_mant);
  assign w_lzc_ext = (EXP_W+1)'(w_lzc);
`endif

  assign w_same  = (r_sign == r_sign2);
  assign w_ge    = (r_m1 >= r_m2);
  assign w_sum   = {1'b0, r_m1} + {1'b0, r_m2};
  assign w_diff  = w_ge ? ({1'b0, r_m1} - {1'b0, r_m2}) : ({1'b0, r_m2} - {1'b0, r_m1});
  assign w_m     = w_same ? w_sum : w_diff;

  // mant[2:0] are G,R,S; mant[3] is the fraction LSB used for the tie break
  assign w_up    = r_mant[2] & (r_mant[1] | r_mant[0] | r_mant[3]);
  assign w_rnd   = {1'b0, r_mant[MW-1:3]} + (FRAC_W+2)'(w_up);
  assign w_exp_r = r_exp + (EXP_W+1)'(w_rnd[FRAC_W+1]);

  always_comb begin
    w_next     = r_state;
    w_exp_n    = r_exp;
    w_sign_n   = r_sign;
    w_sign2_n  = r_sign2;
    w_m1_n     = r_m1;
    w_m2_n     = r_m2;
    w_mant_n   = r_mant;
    w_result_n = r_result;
    w_ovf_n    = r_ovf;
    w_unf_n    = r_unf;
    in_ready   = 1'b0;
    out_valid  = 1'b0;

    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_exp_n   = {1'b0, e};
          w_sign_n  = sign;
          w_sign2_n = sign_2;
          w_m1_n    = m_1;
          w_m2_n    = m_2;
          w_ovf_n   = 1'b0;
          w_unf_n   = 1'b0;
          w_next    = S_ADD;
        end
      end

      S_ADD: begin
        if (!w_same && !w_ge) w_sign_n = r_sign2;
        if (w_m == '0) begin
          w_result_n = '0;
          w_next     = S_DONE;
        end else if (w_m[MW]) begin
          w_mant_n = {w_m[MW:2], w_m[1] | w_m[0]};
          w_exp_n  = r_exp + EXP_ONE;
          w_next   = S_ROUND;
        end else begin
          w_mant_n = w_m[MW-1:0];
          w_next   = w_m[MW-1] ? S_ROUND : S_NORM;
        end
      end

      S_NORM: begin
`ifdef FP_NORM_LZC_EN
        if (w_lzc_ext + EXP_ONE > r_exp) begin
          w_result_n = {r_sign, {(EXP_W+FRAC_W){1'b0}}};
          w_unf_n    = 1'b1;
          w_next     = S_DONE;
        end else begin
          w_mant_n = r_mant << w_lzc;
          w_exp_n  = r_exp - w_lzc_ext;
          w_next   = S_ROUND;
        end
`else
        // Leave as soon as the shifted value is normalized so k shifts cost k cycles
        if (r_mant[MW-1]) begin
          w_next = S_ROUND;
        end else if (r_exp > EXP_ONE) begin
          w_mant_n = {r_mant[MW-2:0], 1'b0};
          w_exp_n  = r_exp - EXP_ONE;
          w_next   = r_mant[MW-2] ? S_ROUND : S_NORM;
        end else begin
          w_result_n = {r_sign, {(EXP_W+FRAC_W){1'b0}}};
          w_unf_n    = 1'b1;
          w_next     = S_DONE;
        end
`endif
      end

      S_ROUND: begin
        if (w_exp_r >= EXP_MAX) begin
          w_result_n = {r_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
          w_ovf_n    = 1'b1;
        end else begin
          w_result_n = {r_sign, w_exp_r[EXP_W-1:0], w_rnd[FRAC_W-1:0]};
        end
        w_next = S_DONE;
      end

      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = S_IDLE;
      end

      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_exp    <= '0;
      r_sign   <= 1'b0;
      r_sign2  <= 1'b0;
      r_m1     <= '0;
      r_m2     <= '0;
      r_mant   <= '0;
      r_result <= '0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_exp    <= w_exp_n;
      r_sign   <= w_sign_n;
      r_sign2  <= w_sign2_n;
      r_m1     <= w_m1_n;
      r_m2     <= w_m2_n;
      r_mant   <= w_mant_n;
      r_result <= w_result_n;
      r_ovf    <= w_ovf_n;
      r_unf    <= w_unf_n;
    end
  end

  assign result    = r_result;
  assign overflow  = r_ovf;
  assign underflow = r_unf;

endmodule

// File: tb/tb_fp_add_normalizer.sv
// Directed self-checking bench for fp_add_normalizer (latency expectations follow FP_NORM_LZC_EN).
module tb_fp_add_normalizer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  e = '0;
  logic        sign = 1'b0;
  logic        sign_2 = 1'b0;
  logic [26:0] m_1 = '0;
  logic [26:0] m_2 = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        overflow;
  logic        underflow;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       name;
    logic [7:0]  e;
    logic        s;
    logic        s2;
    logic [26:0] m1;
    logic [26:0] m2;
    logic [31:0] res;
    logic        ovf;
    logic        unf;
    int          lat;
  } vec_t;

  fp_add_normalizer #(.EXP_W(8), .FRAC_W(23)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .e(e), .sign(sign), .sign_2(sign_2), .m_1(m_1), .m_2(m_2),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  function automatic int norm_lat(input int k);
`ifdef FP_NORM_LZC_EN
    return (k == 0) ? 3 : 4;
`else
    return 3 + k;
`endif
  endfunction

  // Handshake edge is cycle 0; lat is the cycle in which out_valid is first seen.
  task automatic do_op(input logic [7:0] te, input logic ts, input logic ts2,
                       input logic [26:0] tm1, input logic [26:0] tm2,
                       output logic [31:0] res, output logic ovf, output logic unf,
                       output int lat);
    @(negedge clk);
    e = te; sign = ts; sign_2 = ts2; m_1 = tm1; m_2 = tm2; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    res = result; ovf = overflow; unf = underflow;
    if (out_ready) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic run_table(input vec_t vs[]);
    logic [31:0] res;
    logic ovf, unf;
    int lat;
    foreach (vs[i]) begin
      do_op(vs[i].e, vs[i].s, vs[i].s2, vs[i].m1, vs[i].m2, res, ovf, unf, lat);
      n_checks++;
      if (res !== vs[i].res) begin
        n_fail++; $display("FAIL %s result got %h want %h", vs[i].name, res, vs[i].res);
      end
      n_checks++;
      if (ovf !== vs[i].ovf) begin
        n_fail++; $display("FAIL %s overflow got %b want %b", vs[i].name, ovf, vs[i].ovf);
      end
      n_checks++;
      if (unf !== vs[i].unf) begin
        n_fail++; $display("FAIL %s underflow got %b want %b", vs[i].name, unf, vs[i].unf);
      end
      n_checks++;
      if (lat != vs[i].lat) begin
        n_fail++; $display("FAIL %s latency got %0d want %0d", vs[i].name, lat, vs[i].lat);
      end
    end
  endtask

  task automatic test_reset;
    n_checks++;
    if ({in_ready, out_valid, result, overflow, underflow} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state got rdy=%b vld=%b res=%h ovf=%b unf=%b want rdy=1 vld=0 res=0 ovf=0 unf=0",
               in_ready, out_valid, result, overflow, underflow);
    end
  endtask

  task automatic test_add;
    vec_t vs[] = new[3];
    vs[0] = '{"add_1p1",    8'd127, 1'b0, 1'b0, 27'h4000000, 27'h4000000, 32'h40000000, 1'b0, 1'b0, 3};
    vs[1] = '{"add_neg",    8'd127, 1'b1, 1'b1, 27'h4000000, 27'h4000000, 32'hC0000000, 1'b0, 1'b0, 3};
    vs[2] = '{"cancel_1m1", 8'd127, 1'b0, 1'b1, 27'h4000000, 27'h4000000, 32'h00000000, 1'b0, 1'b0, 2};
    run_table(vs);
  endtask

  task automatic test_norm;
    vec_t vs[] = new[3];
    vs[0] = '{"sub_1m05",   8'd127, 1'b0, 1'b1, 27'h4000000, 27'h2000000, 32'h3F000000, 1'b0, 1'b0, norm_lat(1)};
    vs[1] = '{"sub_05m1",   8'd127, 1'b0, 1'b1, 27'h2000000, 27'h4000000, 32'hBF000000, 1'b0, 1'b0, norm_lat(1)};
    vs[2] = '{"sub_shift20",8'd127, 1'b0, 1'b1, 27'h4000000, 27'h3FFFFC0, 32'h35800000, 1'b0, 1'b0, norm_lat(20)};
    run_table(vs);
  endtask

  task automatic test_round;
    vec_t vs[] = new[3];
    vs[0] = '{"rne_carry",  8'd127, 1'b0, 1'b0, 27'h7FFFFF8, 27'h0000004, 32'h40000000, 1'b0, 1'b0, 3};
    vs[1] = '{"rne_tie_even",8'd127,1'b0, 1'b0, 27'h4000000, 27'h0000004, 32'h3F800000, 1'b0, 1'b0, 3};
    vs[2] = '{"rne_above",  8'd127, 1'b0, 1'b0, 27'h4000000, 27'h0000006, 32'h3F800001, 1'b0, 1'b0, 3};
    run_table(vs);
  endtask

  task automatic test_overflow_underflow;
    vec_t vs[] = new[3];
    vs[0] = '{"overflow",   8'd254, 1'b0, 1'b0, 27'h4000000, 27'h4000000, 32'h7F800000, 1'b1, 1'b0, 3};
    vs[1] = '{"unf_e1",     8'd1,   1'b0, 1'b1, 27'h4000000, 27'h2000000, 32'h00000000, 1'b0, 1'b1, 3};
`ifdef FP_NORM_LZC_EN
    vs[2] = '{"unf_neg_e3", 8'd3,   1'b1, 1'b0, 27'h4000000, 27'h3FFFFC0, 32'h80000000, 1'b0, 1'b1, 3};
`else
    vs[2] = '{"unf_neg_e3", 8'd3,   1'b1, 1'b0, 27'h4000000, 27'h3FFFFC0, 32'h80000000, 1'b0, 1'b1, 5};
`endif
    run_table(vs);
  endtask

  task automatic test_backpressure;
    logic [31:0] res;
    logic ovf, unf;
    int lat;
    out_ready = 1'b0;
    do_op(8'd127, 1'b0, 1'b0, 27'h4000000, 27'h4000000, res, ovf, unf, lat);
    n_checks++;
    if (res !== 32'h40000000 || lat != 3) begin
      n_fail++; $display("FAIL bp_first got res=%h lat=%0d want res=40000000 lat=3", res, lat);
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({out_valid, in_ready, result} !== {1'b1, 1'b0, 32'h40000000}) begin
        n_fail++;
        $display("FAIL bp_stall[%0d] got vld=%b rdy=%b res=%h want vld=1 rdy=0 res=40000000",
                 i, out_valid, in_ready, result);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_fail++; $display("FAIL bp_release got vld=%b rdy=%b want vld=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_in_norm;
    vec_t vs[] = new[1];
    @(negedge clk);
    e = 8'd127; sign = 1'b0; sign_2 = 1'b1; m_1 = 27'h4000000; m_2 = 27'h0000040; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({out_valid, in_ready, result} !== {1'b0, 1'b1, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_in_norm got vld=%b rdy=%b res=%h want vld=0 rdy=1 res=0",
               out_valid, in_ready, result);
    end
    @(negedge clk);
    reset = 1'b0;
    vs[0] = '{"after_reset", 8'd127, 1'b0, 1'b1, 27'h4000000, 27'h0000040, 32'h3F7FFFF0, 1'b0, 1'b0, norm_lat(1)};
    run_table(vs);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    test_reset;
    @(negedge clk);
    reset = 1'b0;
    test_add;
    test_norm;
    test_round;
    test_overflow_underflow;
    test_backpressure;
    test_reset_in_norm;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
